// File: rtl/wb_arbiter_if.sv
// Purpose : bundle of the writeback arbiter's channel handshake and register-file
//           write signals.
// Modports: master - functional-unit side (drives src_*, observes ready and wb outputs)
//           slave  - arbiter side (consumes src_*, drives src_ready and *_wb, wb_count)
// Params  : NSRC channels, XLEN data width, CNTW committed-write counter width
interface wb_arbiter_if #(
   parameter int unsigned NSRC = 4,
   parameter int unsigned XLEN = 64,
   parameter int unsigned CNTW = 32
);
   logic [NSRC-1:0]      src_valid;
   logic [NSRC-1:0]      src_ready;
   logic [NSRC*5-1:0]    src_rd;
   logic [NSRC-1:0]      src_type;
   logic [NSRC-1:0]      src_we;
   logic [NSRC*XLEN-1:0] src_data;
   logic [4:0]           rd_wb;
   logic                 reg_type_wb;
   logic [XLEN-1:0]      op_wb;
   logic                 we_rd_wb;
   logic [CNTW-1:0]      wb_count;

   modport master (
      output src_valid, src_rd, src_type, src_we, src_data,
      input  src_ready, rd_wb, reg_type_wb, op_wb, we_rd_wb, wb_count
   );

   modport slave (
      input  src_valid, src_rd, src_type, src_we, src_data,
      output src_ready, rd_wb, reg_type_wb, op_wb, we_rd_wb, wb_count
   );
endinterface

// File: rtl/wb_arbiter.sv
// Purpose : writeback stage feeding the single register-file write port. Round-robin
//           arbitration over NSRC result channels, one registered write per cycle,
//           committed-write counter.
// Ports   : clk, n_reset (async, active-low), bus (wb_arbiter_if.slave)
//           src_ready is combinational (zero while n_reset is low); *_wb and wb_count
//           are registered.
// Config  : define WB_FWD_EN to add the decode-operand forwarding ports
//           rs1_dec/rs2_dec/rs3_dec, reg_type_dec, op1_rf/op2_rf/op3_rf (in) and
//           op1_fwd/op2_fwd/op3_fwd (out, combinational). Absent by default.
module wb_arbiter #(
   parameter int unsigned NSRC = 4,
   parameter int unsigned XLEN = 64,
   parameter int unsigned CNTW = 32
) (
   input  logic            clk,
   input  logic            n_reset,
   wb_arbiter_if.slave     bus
`ifdef WB_FWD_EN
   ,
   input  logic [4:0]      rs1_dec,
   input  logic [4:0]      rs2_dec,
   input  logic [4:0]      rs3_dec,
   input  logic            reg_type_dec,
   input  logic [XLEN-1:0] op1_rf,
   input  logic [XLEN-1:0] op2_rf,
   input  logic [XLEN-1:0] op3_rf,
   output logic [XLEN-1:0] op1_fwd,
   output logic [XLEN-1:0] op2_fwd,
   output logic [XLEN-1:0] op3_fwd
`endif
);

   localparam int unsigned PTRW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
   logic [4:0]      rd_wb_q, rd_wb_d;
   logic            reg_type_wb_q, reg_type_wb_d;
   logic [XLEN-1:0] op_wb_q, op_wb_d;
   logic            we_rd_wb_q, we_rd_wb_d;
   logic [CNTW-1:0] wb_count_q, wb_count_d;

   logic            gnt_vld;
   logic [PTRW-1:0] gnt_idx;
   logic [4:0]      sel_rd;
   logic            sel_type;
   logic            sel_we;
   logic [XLEN-1:0] sel_data;

   // Round-robin search starting at rr_ptr; first valid channel wins.
   always_comb begin : arb
      int unsigned idx;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         idx = (32'(rr_ptr_q) + k) % NSRC;
         if (!gnt_vld && bus.src_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTRW'(idx);
         end
      end
   end

   // Payload of the granted channel.
   always_comb begin : sel
      int unsigned g;
      g        = 32'(gnt_idx);
      sel_rd   = bus.src_rd[5*g +: 5];
      sel_type = bus.src_type[g];
      sel_we   = bus.src_we[g];
      sel_data = bus.src_data[XLEN*g +: XLEN];
   end

   // The register file never stalls, so the grant is the handshake.
   always_comb begin : ready
      bus.src_ready = '0;
      if (n_reset && gnt_vld) begin
         bus.src_ready[gnt_idx] = 1'b1;
      end
   end

   // Next-state: capture granted result, advance pointer, count committed writes.
   always_comb begin : nxt
      rr_ptr_d      = rr_ptr_q;
      rd_wb_d       = rd_wb_q;
      reg_type_wb_d = reg_type_wb_q;
      op_wb_d       = op_wb_q;
      we_rd_wb_d    = 1'b0;
      wb_count_d    = wb_count_q + CNTW'(we_rd_wb_q);
      if (gnt_vld) begin
         rr_ptr_d      = (gnt_idx == PTRW'(NSRC - 1)) ? '0 : gnt_idx + PTRW'(1);
         rd_wb_d       = sel_rd;
         reg_type_wb_d = sel_type;
         op_wb_d       = sel_data;
         // Integer x0 is hardwired zero; float f0 is a real register.
         we_rd_wb_d    = sel_we & ~(~sel_type & (sel_rd == 5'd0));
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin : regs
      if (!n_reset) begin
         rr_ptr_q      <= '0;
         rd_wb_q       <= '0;
         reg_type_wb_q <= 1'b0;
         op_wb_q       <= '0;
         we_rd_wb_q    <= 1'b0;
         wb_count_q    <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         rd_wb_q       <= rd_wb_d;
         reg_type_wb_q <= reg_type_wb_d;
         op_wb_q       <= op_wb_d;
         we_rd_wb_q    <= we_rd_wb_d;
         wb_count_q    <= wb_count_d;
      end
   end

   assign bus.rd_wb       = rd_wb_q;
   assign bus.reg_type_wb = reg_type_wb_q;
   assign bus.op_wb       = op_wb_q;
   assign bus.we_rd_wb    = we_rd_wb_q;
   assign bus.wb_count    = wb_count_q;

`ifdef WB_FWD_EN
   // Bypass the write being committed this cycle to decode operand reads.
   function automatic logic fwd_hit(input logic [4:0] rs);
      return we_rd_wb_q && (rd_wb_q == rs) && (reg_type_wb_q == reg_type_dec) &&
             !(!reg_type_wb_q && (rd_wb_q == 5'd0));
   endfunction

   always_comb begin : fwd
      op1_fwd = fwd_hit(rs1_dec) ? op_wb_q : op1_rf;
      op2_fwd = fwd_hit(rs2_dec) ? op_wb_q : op2_rf;
      op3_fwd = fwd_hit(rs3_dec) ? op_wb_q : op3_rf;
   end
`endif

endmodule
